// File: rtl/audio_env_volume_if.sv
// Sample, envelope-control and volume signals between the note generator side and the
// envelope/volume stage.
interface audio_env_volume_if;
  logic               gate;
  logic               retrig;
  logic               vol_up;
  logic               vol_down;
  logic signed [15:0] audio_in_left;
  logic signed [15:0] audio_in_right;
  logic signed [15:0] audio_out_left;
  logic signed [15:0] audio_out_right;
  logic               out_valid;
  logic               sample_tick;
  logic [2:0]         volume;
  logic [1:0]         env_state;

  modport master (
    output gate, retrig, vol_up, vol_down, audio_in_left, audio_in_right,
    input  audio_out_left, audio_out_right, out_valid, sample_tick, volume, env_state
  );

  modport slave (
    input  gate, retrig, vol_up, vol_down, audio_in_left, audio_in_right,
    output audio_out_left, audio_out_right, out_valid, sample_tick, volume, env_state
  );
endinterface

// File: rtl/audio_env_volume.sv
// Attack/sustain/release envelope plus 8-level volume shift on 16-bit stereo samples,
// with a self-generated sample-rate strobe and a two-stage output pipeline.
module audio_env_volume #(
  parameter int SAMPLE_DIV   = 512,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8,
  parameter int VOL_INIT     = 4
) (
  input logic               clk,
  input logic               rst,
  audio_env_volume_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int         CW    = $clog2(SAMPLE_DIV);
  localparam logic [8:0] ATK   = 9'(ATTACK_STEP);
  localparam logic [8:0] REL   = 9'(RELEASE_STEP);
  localparam logic [8:0] UNITY = 9'd256;

  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          trig_q;
  logic          trig;
  logic [8:0]    env_q, env_d;
  logic [9:0]    env_sum;
  logic [8:0]    env_up, env_dn;
  env_state_t    state_q, state_d;
  logic [2:0]    vol_q;

  logic signed [25:0] prod_l, prod_r;
  logic signed [15:0] p_l_q, p_r_q;
  logic               v1_q;
  logic [2:0]         shamt;
  logic signed [15:0] sh_l, sh_r;
  logic signed [15:0] out_l_q, out_r_q;
  logic               out_valid_q;

  assign tick = (cnt_q == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)      cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // A retrig in the tick cycle itself is seen directly, so it is consumed by that tick.
  assign trig = trig_q | bus.retrig;

  always_ff @(posedge clk) begin
    if (!rst)            trig_q <= 1'b0;
    else if (tick)       trig_q <= 1'b0;
    else if (bus.retrig) trig_q <= 1'b1;
  end

  assign env_sum = {1'b0, env_q} + {1'b0, ATK};
  assign env_up  = (env_sum > {1'b0, UNITY}) ? UNITY : env_sum[8:0];
  assign env_dn  = (env_q > REL) ? (env_q - REL) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (bus.gate || trig) begin
            state_d = ATTACK;
            env_d   = env_up;
          end
        end
        ATTACK: begin
          if (!bus.gate) begin
            state_d = RELEASE;
            env_d   = env_dn;
          end else begin
            env_d = env_up;
            if (env_up == UNITY) state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!bus.gate) begin
            state_d = RELEASE;
            env_d   = env_dn;
          end else if (trig) begin
            state_d = ATTACK;
          end
        end
        RELEASE: begin
          if (bus.gate || trig) begin
            state_d = ATTACK;
            env_d   = env_up;
          end else begin
            env_d = env_dn;
            if (env_dn == '0) state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vol_q <= 3'(VOL_INIT);
    end else if (bus.vol_up && !bus.vol_down && vol_q != 3'd7) begin
      vol_q <= vol_q + 3'd1;
    end else if (bus.vol_down && !bus.vol_up && vol_q != 3'd0) begin
      vol_q <= vol_q - 3'd1;
    end
  end

  // env is unsigned 0..256; zero-extend it so the product stays signed and exact.
  assign prod_l = $signed({{10{bus.audio_in_left[15]}}, bus.audio_in_left})   * $signed({17'd0, env_q});
  assign prod_r = $signed({{10{bus.audio_in_right[15]}}, bus.audio_in_right}) * $signed({17'd0, env_q});

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_l_q <= '0;
      p_r_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= tick;
      if (tick) begin
        p_l_q <= 16'(prod_l >>> 8);
        p_r_q <= 16'(prod_r >>> 8);
      end
    end
  end

  assign shamt = 3'd7 - vol_q;
  assign sh_l  = p_l_q >>> shamt;
  assign sh_r  = p_r_q >>> shamt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_l_q <= (vol_q == 3'd0) ? '0 : sh_l;
        out_r_q <= (vol_q == 3'd0) ? '0 : sh_r;
      end
    end
  end

  assign bus.audio_out_left  = out_l_q;
  assign bus.audio_out_right = out_r_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.sample_tick     = tick;
  assign bus.volume          = vol_q;
  assign bus.env_state       = state_q;

endmodule

// File: tb/tb_audio_env_volume.sv
// Self-checking bench for audio_env_volume: directed scenarios followed by random traffic,
// every cycle compared against an arithmetic reference model of the envelope and gain rules.
module tb_audio_env_volume;
  localparam int DIV   = 4;
  localparam int ATK   = 64;
  localparam int REL   = 32;
  localparam int VINIT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  audio_env_volume_if bus();

  audio_env_volume #(
    .SAMPLE_DIV  (DIV),
    .ATTACK_STEP (ATK),
    .RELEASE_STEP(REL),
    .VOL_INIT    (VINIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  // reference model state
  int m_cnt, m_env, m_state, m_vol, m_pl, m_pr, m_ol, m_or;
  bit m_trig, m_v1, m_ov;

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    ntotal++;
    nfail++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Envelope rules: 0 idle, 1 attack, 2 sustain, 3 release.
  task automatic env_rule(input bit g, input bit t);
    case (m_state)
      0: if (g || t) begin m_state = 1; m_env = imin(m_env + ATK, 256); end
      1: if (!g) begin m_state = 3; m_env = imax(m_env - REL, 0); end
         else begin m_env = imin(m_env + ATK, 256); if (m_env == 256) m_state = 2; end
      2: if (!g) begin m_state = 3; m_env = imax(m_env - REL, 0); end
         else if (t) m_state = 1;
      default: if (g || t) begin m_state = 1; m_env = imin(m_env + ATK, 256); end
               else begin m_env = imax(m_env - REL, 0); if (m_env == 0) m_state = 0; end
    endcase
  endtask

  // Advance the model over the coming edge, clock it, then compare every output.
  task automatic cyc();
    bit tk;
    if (!rst) begin
      m_cnt = 0; m_env = 0; m_state = 0; m_vol = VINIT; m_trig = 0;
      m_v1 = 0; m_pl = 0; m_pr = 0; m_ol = 0; m_or = 0; m_ov = 0;
    end else begin
      tk   = (m_cnt == DIV - 1);
      m_ov = m_v1;
      if (m_v1) begin
        m_ol = (m_vol == 0) ? 0 : fdiv(m_pl, 1 << (7 - m_vol));
        m_or = (m_vol == 0) ? 0 : fdiv(m_pr, 1 << (7 - m_vol));
      end
      m_v1 = tk;
      if (tk) begin
        m_pl = fdiv(int'(bus.audio_in_left) * m_env, 256);
        m_pr = fdiv(int'(bus.audio_in_right) * m_env, 256);
        env_rule(bus.gate, m_trig || bus.retrig);
        m_trig = 0;
      end else if (bus.retrig) begin
        m_trig = 1;
      end
      if (bus.vol_up && !bus.vol_down)      m_vol = imin(m_vol + 1, 7);
      else if (bus.vol_down && !bus.vol_up) m_vol = imax(m_vol - 1, 0);
      m_cnt = (m_cnt + 1) % DIV;
    end
    @(posedge clk);
    #1;
    chk("sample_tick", bus.sample_tick, (m_cnt == DIV - 1));
    chk("out_valid", bus.out_valid, m_ov);
    chk("env_state", bus.env_state, m_state);
    chk("volume", bus.volume, m_vol);
    chk("out_left", bus.audio_out_left, m_ol);
    chk("out_right", bus.audio_out_right, m_or);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      cyc();
      if (bus.out_valid === 1'b1) return;
    end
    timeout_fail("wait_valid");
  endtask

  // Returns just after the edge that ends a sample_tick cycle.
  task automatic wait_tick();
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      if (bus.sample_tick === 1'b1) begin
        cyc();
        return;
      end
      cyc();
    end
    timeout_fail("wait_tick");
  endtask

  task automatic pulse_vol(input bit up, input bit down, input int n);
    for (int i = 0; i < n; i++) begin
      bus.vol_up = up; bus.vol_down = down;
      cyc();
      bus.vol_up = 1'b0; bus.vol_down = 1'b0;
    end
  endtask

  initial begin
    int n;
    bus.gate = 1'b0; bus.retrig = 1'b0; bus.vol_up = 1'b0; bus.vol_down = 1'b0;
    bus.audio_in_left = '0; bus.audio_in_right = '0;
    rst = 1'b0;
    cyc();
    cyc();

    // T1: attack ramp from reset at full volume
    rst = 1'b1;
    bus.gate = 1'b1;
    bus.audio_in_left = 16'sd1000; bus.audio_in_right = 16'sd1000;
    for (int k = 1; k <= 5; k++) begin
      wait_valid();
      chk("t1_out_l", bus.audio_out_left, (k - 1) * 250);
      chk("t1_out_r", bus.audio_out_right, (k - 1) * 250);
      chk("t1_state", bus.env_state, (k >= 4) ? 2 : 1);
    end

    // T2: release to idle, then re-attack from the middle of a release
    bus.gate = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wait_valid();
      chk("t2_rel_out", bus.audio_out_left, fdiv(1000 * (256 - REL * (k - 1)), 256));
      chk("t2_rel_state", bus.env_state, (k == 8) ? 0 : 3);
    end
    wait_valid();
    chk("t2_idle_out", bus.audio_out_left, 0);
    bus.gate = 1'b1;
    for (int k = 0; k < 4; k++) wait_valid();
    chk("t2_sustain", bus.env_state, 2);
    bus.gate = 1'b0;
    for (int k = 0; k < 5; k++) wait_valid();
    bus.gate = 1'b1;
    wait_valid();
    chk("t2_reatk_out96", bus.audio_out_left, 375);
    chk("t2_reatk_state", bus.env_state, 1);
    wait_valid();
    chk("t2_reatk_out160", bus.audio_out_left, 625);
    wait_valid();
    wait_valid();
    chk("t2_back_sustain", bus.env_state, 2);

    // T3: volume control
    bus.audio_in_right = -16'sd1000;
    pulse_vol(1'b0, 1'b1, 3);
    chk("t3_vol4", bus.volume, 4);
    wait_valid();
    wait_valid();
    chk("t3_out_pos", bus.audio_out_left, 125);
    chk("t3_out_neg", bus.audio_out_right, -125);
    pulse_vol(1'b0, 1'b1, 5);
    chk("t3_vol0", bus.volume, 0);
    wait_valid();
    chk("t3_mute_l", bus.audio_out_left, 0);
    chk("t3_mute_r", bus.audio_out_right, 0);
    pulse_vol(1'b1, 1'b0, 9);
    chk("t3_vol7", bus.volume, 7);
    pulse_vol(1'b0, 1'b1, 1);
    pulse_vol(1'b1, 1'b1, 1);
    chk("t3_both", bus.volume, 6);
    pulse_vol(1'b1, 1'b0, 1);

    // T4: retrig from sustain and from release
    bus.audio_in_right = 16'sd1000;
    n = 0;
    while (m_cnt != DIV - 3 && n < 2 * DIV) begin cyc(); n++; end
    bus.retrig = 1'b1;
    cyc();
    bus.retrig = 1'b0;
    wait_tick();
    chk("t4_sus_retrig", bus.env_state, 1);
    wait_tick();
    chk("t4_sus_back", bus.env_state, 2);
    bus.gate = 1'b0;
    for (int k = 0; k < 6; k++) wait_tick();
    chk("t4_release", bus.env_state, 3);
    bus.retrig = 1'b1;
    cyc();
    bus.retrig = 1'b0;
    wait_tick();
    chk("t4_rel_retrig", bus.env_state, 1);
    wait_valid();
    chk("t4_out64", bus.audio_out_left, 250);
    wait_valid();
    chk("t4_out128", bus.audio_out_left, 500);
    chk("t4_to_release", bus.env_state, 3);

    // T5: reset mid-attack with a sample in flight
    bus.gate = 1'b1;
    for (int k = 0; k < 8; k++) wait_tick();
    bus.gate = 1'b0;
    wait_tick();
    bus.gate = 1'b1;
    wait_tick();
    chk("t5_pre_attack", bus.env_state, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("t5_out_l", bus.audio_out_left, 0);
    chk("t5_out_r", bus.audio_out_right, 0);
    chk("t5_state", bus.env_state, 0);
    chk("t5_volume", bus.volume, VINIT);
    chk("t5_valid", bus.out_valid, 0);
    n = 1;
    while (bus.sample_tick !== 1'b1 && n < 3 * DIV) begin cyc(); n++; end
    chk("t5_first_tick", n, DIV);

    // T6: rounding of -1 and full-scale positive
    for (int k = 0; k < 6; k++) wait_tick();
    chk("t6_sustain", bus.env_state, 2);
    bus.audio_in_left = -16'sd1; bus.audio_in_right = -16'sd1;
    pulse_vol(1'b0, 1'b1, 6);
    chk("t6_vol1", bus.volume, 1);
    wait_valid();
    wait_valid();
    chk("t6_neg1_l", bus.audio_out_left, -1);
    chk("t6_neg1_r", bus.audio_out_right, -1);
    bus.audio_in_left = 16'sh7FFF; bus.audio_in_right = 16'sh7FFF;
    pulse_vol(1'b1, 1'b0, 6);
    wait_valid();
    wait_valid();
    chk("t6_max_l", bus.audio_out_left, 32767);
    chk("t6_max_r", bus.audio_out_right, 32767);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.audio_in_left  = 16'($urandom);
      bus.audio_in_right = 16'($urandom);
      if ($urandom_range(7) == 0) bus.gate = ~bus.gate;
      bus.retrig   = ($urandom_range(15) == 0);
      bus.vol_up   = ($urandom_range(9) == 0);
      bus.vol_down = ($urandom_range(9) == 0);
      cyc();
    end
    bus.retrig = 1'b0; bus.vol_up = 1'b0; bus.vol_down = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
